// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures the high time of a 1-2 ms pulse and
// converts it back to a 0-180 degree angle, with a validity watchdog.
module servo_pwm_decoder #(
  parameter int MIN_PULSE      = 50_000,
  parameter int MAX_PULSE      = 100_000,
  parameter int CYCLES_PER_DEG = 278,
  parameter int TOL            = 2_500,
  parameter int TIMEOUT        = 1_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic        angle_strobe,
  output logic        angle_valid,
  output logic [16:0] pulse_width,
  output logic        err_pulse
);

  localparam logic [16:0] CNT_MAX = 17'h1ffff;
  localparam logic [16:0] LO_LIM  = 17'(MIN_PULSE - TOL);
  localparam logic [16:0] HI_LIM  = 17'(MAX_PULSE + TOL);
  localparam logic [16:0] MIN_W   = 17'(MIN_PULSE);
  localparam logic [16:0] CPD     = 17'(CYCLES_PER_DEG);
  localparam logic [16:0] HALF    = 17'(CYCLES_PER_DEG / 2);
  localparam logic [20:0] TMO     = 21'(TIMEOUT);
  localparam logic [7:0]  MAX_DEG = 8'd180;

  typedef enum logic [1:0] {IDLE, HIGH, CONV} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] rem_q, rem_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  angle_q, angle_d;
  logic        strobe_q, strobe_d;
  logic        valid_q, valid_d;
  logic [16:0] width_q, width_d;
  logic        err_q, err_d;
  logic [20:0] wd_q, wd_d;

  logic rise, fall, bad_w, step;

  // A level seen high right after reset is not a rise: arm only once
  // the synchronizer holds real samples and the input is seen low.
  assign rise  = s2_q & ~s3_q & armed_q;
  assign fall  = ~s2_q & s3_q;
  assign bad_w = (cnt_q < LO_LIM) | (cnt_q > HI_LIM);
  assign step  = (rem_q >= CPD) & (acc_q < MAX_DEG);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      fill_q   <= '0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      angle_q  <= '0;
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
      width_q  <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      fill_q   <= fill_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      angle_q  <= angle_d;
      strobe_q <= strobe_d;
      valid_q  <= valid_d;
      width_q  <= width_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rise) state_d = HIGH;
      HIGH: if (fall) state_d = bad_w ? IDLE : CONV;
      CONV: if (!step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_d   = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    armed_d  = armed_q | ((fill_q == 2'd3) & ~s2_q);
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    angle_d  = angle_q;
    width_d  = width_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: if (rise) cnt_d = 17'd1;
      HIGH: begin
        if (s2_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 17'd1;
        end else if (fall) begin
          width_d = cnt_q;
          if (bad_w) begin
            err_d = 1'b1;
          end else begin
            rem_d = (cnt_q < MIN_W) ? '0 : cnt_q - MIN_W + HALF;
            acc_d = '0;
          end
        end
      end
      CONV: begin
        if (step) begin
          rem_d = rem_q - CPD;
          acc_d = acc_q + 8'd1;
        end else begin
          angle_d  = acc_q;
          strobe_d = 1'b1;
        end
      end
      default: ;
    endcase
    wd_d = strobe_d ? '0 : (wd_q < TMO) ? wd_q + 21'd1 : wd_q;
    valid_d = strobe_d | (valid_q & (wd_d < TMO));
  end

  assign angle        = angle_q;
  assign angle_strobe = strobe_q;
  assign angle_valid  = valid_q;
  assign pulse_width  = width_q;
  assign err_pulse    = err_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder; timing scaled down
// (900/1800 cycles, 5 per degree) so the run stays short.
module tb_servo_pwm_decoder;

  localparam int MINP = 900;
  localparam int MAXP = 1800;
  localparam int CPD  = 5;
  localparam int TOLP = 45;
  localparam int TMO  = 8000;
  localparam int LOW  = 300;

  typedef struct {
    bit is_err;
    int ang;
    int tol;
    int width;
    int fall;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm = 1'b0;
  logic [7:0]  angle;
  logic        angle_strobe;
  logic        angle_valid;
  logic [16:0] pulse_width;
  logic        err_pulse;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  int   cur_ang = 0;
  exp_t q[$];
  exp_t me;

  servo_pwm_decoder #(
    .MIN_PULSE(MINP),
    .MAX_PULSE(MAXP),
    .CYCLES_PER_DEG(CPD),
    .TOL(TOLP),
    .TIMEOUT(TMO)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .pwm_in(pwm),
    .angle(angle),
    .angle_strobe(angle_strobe),
    .angle_valid(angle_valid),
    .pulse_width(pulse_width),
    .err_pulse(err_pulse)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input int obs,
                      input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Drive one pulse; the expected outcome is queued at the falling edge.
  task automatic pulse(input int hi, input bit is_err,
                       input int ang, input int tol);
    exp_t e;
    @(negedge clk) pwm = 1'b1;
    repeat (hi) @(negedge clk);
    pwm = 1'b0;
    e.is_err = is_err;
    e.ang    = is_err ? cur_ang : ang;
    e.tol    = tol;
    e.width  = hi;
    e.fall   = cyc;
    q.push_back(e);
    if (!is_err) cur_ang = ang;
    repeat (LOW) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && (angle_strobe || err_pulse)) begin
      chk("excl", int'(angle_strobe & err_pulse), 0);
      if (q.size() == 0) begin
        chk("unexpected_out", q.size(), 1);
      end else begin
        me = q.pop_front();
        chk("kind", int'(err_pulse), int'(me.is_err));
        chk("width", int'(pulse_width), me.width);
        if (me.is_err) begin
          chk("err_lat", cyc - me.fall, 3);
          chk("err_angle", int'(angle), me.ang);
        end else begin
          chkr("angle", int'(angle), me.ang - me.tol, me.ang + me.tol);
          chkr("strobe_lat", cyc - me.fall,
               4 + me.ang - me.tol, 4 + me.ang + me.tol);
          chk("valid_on_strobe", int'(angle_valid), 1);
          last_strobe = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    int w;
    int cmds[5] = '{0, 2, 90, 178, 180};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk) pwm = ~pwm;
    end
    chk("rst_angle", int'(angle), 0);
    chk("rst_strobe", int'(angle_strobe), 0);
    chk("rst_valid", int'(angle_valid), 0);
    chk("rst_width", int'(pulse_width), 0);
    chk("rst_err", int'(err_pulse), 0);
    @(negedge clk) pwm = 1'b0;
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_valid", int'(angle_valid), 0);
    chk("idle_angle", int'(angle), 0);

    pulse(1350, 0, 90, 0);
    chk("nom_width", int'(pulse_width), 1350);
    chk("nom_valid", int'(angle_valid), 1);
    pulse(900, 0, 0, 0);
    pulse(1800, 0, 180, 0);

    pulse(882, 0, 0, 0);
    pulse(1827, 0, 180, 0);
    pulse(855, 0, 0, 0);
    pulse(1845, 0, 180, 0);
    pulse(720, 1, 0, 0);
    chk("err_width", int'(pulse_width), 720);
    pulse(1980, 1, 0, 0);
    pulse(854, 1, 0, 0);
    pulse(1846, 1, 0, 0);
    chk("err_keep_angle", int'(angle), 180);

    pulse(1350, 0, 90, 0);
    n = 0;
    while (angle_valid && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chkr("tmo_fall", cyc - last_strobe, TMO, TMO + 1);
    repeat (20) @(negedge clk);
    chk("tmo_valid", int'(angle_valid), 0);
    chk("tmo_angle", int'(angle), 90);
    pulse(1350, 0, 90, 0);
    chk("tmo_revalid", int'(angle_valid), 1);

    @(negedge clk) pwm = 1'b1;
    repeat (540) @(negedge clk);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    chk("mid_angle", int'(angle), 0);
    chk("mid_valid", int'(angle_valid), 0);
    chk("mid_width", int'(pulse_width), 0);
    repeat (300) @(negedge clk);
    pwm = 1'b0;
    repeat (LOW) @(negedge clk);
    chk("mid_width_kept", int'(pulse_width), 0);
    cur_ang = 0;
    pulse(1125, 0, 45, 0);

    foreach (cmds[i]) begin
      w = MINP + (cmds[i] * (MAXP - MINP) + 90) / 180;
      pulse(w, 0, cmds[i], 1);
    end

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
